ahb_lite_master: RTL and testbench
==================================

// Module: ahb_lite_master
// PURPOSE
//  Single-outstanding AHB-Lite initiator driving the USB endpoint's AHB slave register map.
//  Accepts read/write commands on a valid/ready port, runs address and data phases with wait states,
//  and returns one response per command. Sits between the bench/CPU-model command source and the endpoint slave.
// PARAMETERS
//  ADDR_W          7    haddr width (slave map 0x00-0x48)
//  DATA_W          32   hwdata/hrdata width
//  TIMEOUT_CYCLES  16   hready-low cycles before abort (used only with AHBM_TIMEOUT_EN)
// PORTS
//  clk          in   1       system clock, rising edge
//  nRst         in   1       asynchronous active-low reset
//  cmd_valid    in   1       command present
//  cmd_ready    out  1       command accepted when cmd_valid & cmd_ready
//  cmd_write    in   1       1 = write, 0 = read
//  cmd_addr     in   ADDR_W  byte address
//  cmd_size     in   2       00 byte, 01 halfword, 10 word, 11 illegal
//  cmd_wdata    in   DATA_W  write data, low-lane aligned
//  rsp_valid    out  1       one-cycle response pulse
//  rsp_rdata    out  DATA_W  read data, low-lane aligned, zero-extended
//  rsp_error    out  1       bus ERROR, illegal/misaligned command, or timeout
//  rsp_timeout  out  1       abort due to timeout
//  haddr        out  ADDR_W  AHB address
//  hsize        out  2       AHB size
//  hwrite       out  1       AHB direction
//  htrans       out  2       00 IDLE, 10 NONSEQ (no other codes issued)
//  hwdata       out  DATA_W  AHB write data, data phase
//  hrdata       in   DATA_W  AHB read data
//  hready       in   1       slave ready
//  hresp        in   1       slave error response
// BEHAVIOUR
//  Reset (async): state IDLE; htrans=00, haddr/hsize/hwrite/hwdata=0, rsp_*=0, cmd_ready=1 after release.
//  All AHB and rsp outputs registered. cmd_ready = (state==IDLE) & !rsp_valid.
//  FSM IDLE -> ADDR -> DATA -> [ERR2] -> IDLE:
//   IDLE: on accept latch cmd; legal -> ADDR next cycle; illegal -> stay IDLE, rsp_valid=1/rsp_error=1 next cycle, no bus activity.
//   Illegal: size 11; size 01 with addr[0]=1; size 10 with addr[1:0]!=0.
//   ADDR: htrans=10, haddr/hsize/hwrite from cmd; hold all while hready=0; on hready=1 -> DATA.
//   DATA: htrans=00; hwdata = cmd_wdata masked (byte {24'b0,[7:0]}, half {16'b0,[15:0]}, word full), stable until exit.
//    hready=1,hresp=0 -> rsp_valid=1 next cycle, rsp_error=0, reads capture masked hrdata -> IDLE.
//    hready=0,hresp=1 -> ERR2 (first error cycle).
//    hready=0,hresp=0 -> wait.
//   ERR2: htrans=00; on hready=1 -> rsp_valid=1, rsp_error=1, rsp_rdata=0 -> IDLE.
//  Latency (no waits, legal): accept at T, NONSEQ at T+1, data phase T+2, rsp_valid at T+3. Min 3 cycles/transfer.
//  rsp_rdata holds last value between responses; writes set rsp_rdata=0.
//  hready=1,hresp=1 in DATA (protocol violation): treat as error completion, rsp_error=1.
//  Reset mid-transfer: bus returns to IDLE immediately; no response issued for in-flight command.
// CONFIGURATION
//  AHBM_TIMEOUT_EN defined: counter ($clog2(TIMEOUT_CYCLES+1) bits) cleared on entering ADDR and on each hready=1
//   cycle, increments each ADDR/DATA/ERR2 cycle with hready=0; reaching TIMEOUT_CYCLES -> htrans=00,
//   rsp_valid=1, rsp_error=1, rsp_timeout=1 next cycle, -> IDLE.
//  AHBM_TIMEOUT_EN undefined: no counter; waits indefinitely on hready; rsp_timeout tied 0.
// TESTING
//  1. Write word 0x00, wdata 0xDEADBEEF, hready=1 -> htrans=10 @T+1 haddr=0x00 hsize=10 hwrite=1; hwdata=0xDEADBEEF @T+2; rsp_valid @T+3, rsp_error=0.
//  2. Read byte 0x48, hrdata=0x123456AB -> rsp_rdata=0x000000AB; halfword 0x40, hrdata=0xFFFF1234 -> 0x00001234.
//  3. Read word 0x04, hready=0 for 3 data cycles -> hwdata/htrans stable, rsp_valid @T+6 with hrdata value.
//  4. Slave ERROR: data phase hready=0/hresp=1 then hready=1/hresp=1 -> htrans=00 both cycles, rsp_error=1, rsp_rdata=0.
//  5. Halfword read 0x41 and size 11 -> no NONSEQ issued, rsp_valid=1, rsp_error=1 next cycle; cmd_ready low that cycle.
//  6. AHBM_TIMEOUT_EN, hready stuck 0 in ADDR 16 cycles -> rsp_timeout=1, rsp_error=1, htrans=00; nRst low mid-transfer -> htrans=00, no rsp.

Source files
------------

// File: rtl/ahb_lite_master.sv
// Single-outstanding AHB-Lite initiator: one valid/ready command in, one bus transfer, one response pulse out.
// Optional hready-low watchdog is compiled in with `define AHBM_TIMEOUT_EN.
module ahb_lite_master #(
    parameter int ADDR_W         = 7,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic              clk,
    input  logic              nRst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [1:0]        cmd_size,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_error,
    output logic              rsp_timeout,
    output logic [ADDR_W-1:0] haddr,
    output logic [1:0]        hsize,
    output logic              hwrite,
    output logic [1:0]        htrans,
    output logic [DATA_W-1:0] hwdata,
    input  logic [DATA_W-1:0] hrdata,
    input  logic              hready,
    input  logic              hresp
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ADDR = 2'd1;
    localparam logic [1:0] S_DATA = 2'd2;
    localparam logic [1:0] S_ERR2 = 2'd3;

    localparam logic [1:0] HT_IDLE   = 2'b00;
    localparam logic [1:0] HT_NONSEQ = 2'b10;

    // Narrow transfers live in the low lanes; upper bits are forced to zero.
    function automatic logic [DATA_W-1:0] lane_mask(input logic [DATA_W-1:0] d,
                                                    input logic [1:0]        sz);
        logic [DATA_W-1:0] m;
        case (sz)
            2'b00:   m = {{(DATA_W-8){1'b0}}, d[7:0]};
            2'b01:   m = {{(DATA_W-16){1'b0}}, d[15:0]};
            default: m = d;
        endcase
        return m;
    endfunction

    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] haddr_q, haddr_d;
    logic [1:0]        hsize_q, hsize_d;
    logic              hwrite_q, hwrite_d;
    logic [1:0]        htrans_q, htrans_d;
    logic [DATA_W-1:0] hwdata_q, hwdata_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
    logic              rsp_error_q, rsp_error_d;
    logic              cmd_illegal;
    logic              cmd_fire;

    assign cmd_ready   = (state_q == S_IDLE) & ~rsp_valid_q;
    assign cmd_fire    = cmd_valid & cmd_ready;
    assign cmd_illegal = (cmd_size == 2'b11) |
                         ((cmd_size == 2'b01) & cmd_addr[0]) |
                         ((cmd_size == 2'b10) & (cmd_addr[1:0] != 2'b00));

`ifdef AHBM_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             rsp_timeout_q, rsp_timeout_d;
`endif

    always_comb begin
        state_d     = state_q;
        haddr_d     = haddr_q;
        hsize_d     = hsize_q;
        hwrite_d    = hwrite_q;
        htrans_d    = htrans_q;
        hwdata_d    = hwdata_q;
        wdata_d     = wdata_q;
        rsp_valid_d = 1'b0;
        rsp_error_d = 1'b0;
        rsp_rdata_d = rsp_rdata_q;
`ifdef AHBM_TIMEOUT_EN
        cnt_d         = cnt_q;
        rsp_timeout_d = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                if (cmd_fire) begin
                    if (cmd_illegal) begin
                        // Rejected locally: answer next cycle without touching the bus.
                        rsp_valid_d = 1'b1;
                        rsp_error_d = 1'b1;
                        rsp_rdata_d = '0;
                    end else begin
                        state_d  = S_ADDR;
                        htrans_d = HT_NONSEQ;
                        haddr_d  = cmd_addr;
                        hsize_d  = cmd_size;
                        hwrite_d = cmd_write;
                        wdata_d  = lane_mask(cmd_wdata, cmd_size);
`ifdef AHBM_TIMEOUT_EN
                        cnt_d    = '0;
`endif
                    end
                end
            end
            S_ADDR: begin
                if (hready) begin
                    state_d  = S_DATA;
                    htrans_d = HT_IDLE;
                    hwdata_d = wdata_q;
                end
            end
            S_DATA: begin
                if (hready) begin
                    // hresp with hready high is a protocol violation; still report it as an error.
                    state_d     = S_IDLE;
                    rsp_valid_d = 1'b1;
                    rsp_error_d = hresp;
                    rsp_rdata_d = (!hresp && !hwrite_q) ? lane_mask(hrdata, hsize_q) : '0;
                end else if (hresp) begin
                    state_d = S_ERR2;
                end
            end
            default: begin
                if (hready) begin
                    state_d     = S_IDLE;
                    rsp_valid_d = 1'b1;
                    rsp_error_d = 1'b1;
                    rsp_rdata_d = '0;
                end
            end
        endcase
`ifdef AHBM_TIMEOUT_EN
        // Watchdog overrides whatever the phase logic decided on the cycle it expires.
        if (state_q != S_IDLE) begin
            if (hready) begin
                cnt_d = '0;
            end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                cnt_d         = '0;
                state_d       = S_IDLE;
                htrans_d      = HT_IDLE;
                rsp_valid_d   = 1'b1;
                rsp_error_d   = 1'b1;
                rsp_timeout_d = 1'b1;
                rsp_rdata_d   = '0;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
`endif
    end

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            state_q     <= S_IDLE;
            haddr_q     <= '0;
            hsize_q     <= '0;
            hwrite_q    <= 1'b0;
            htrans_q    <= HT_IDLE;
            hwdata_q    <= '0;
            wdata_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_error_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            haddr_q     <= haddr_d;
            hsize_q     <= hsize_d;
            hwrite_q    <= hwrite_d;
            htrans_q    <= htrans_d;
            hwdata_q    <= hwdata_d;
            wdata_q     <= wdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_error_q <= rsp_error_d;
        end
    end

`ifdef AHBM_TIMEOUT_EN
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            cnt_q         <= '0;
            rsp_timeout_q <= 1'b0;
        end else begin
            cnt_q         <= cnt_d;
            rsp_timeout_q <= rsp_timeout_d;
        end
    end
    assign rsp_timeout = rsp_timeout_q;
`else
    // No watchdog: TIMEOUT_CYCLES only keeps the parameter list identical across builds.
    localparam bit TIMEOUT_CFG_OK = (TIMEOUT_CYCLES > 0);
    assign rsp_timeout = 1'b0 & TIMEOUT_CFG_OK;
`endif

    assign haddr     = haddr_q;
    assign hsize     = hsize_q;
    assign hwrite    = hwrite_q;
    assign htrans    = htrans_q;
    assign hwdata    = hwdata_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_error = rsp_error_q;

endmodule

// File: tb/tb_ahb_lite_master.sv
// Bench for ahb_lite_master: vector table driven cycle by cycle, responses checked from a queue.
module tb_ahb_lite_master;

    logic        clk = 1'b0;
    logic        nRst;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [6:0]  cmd_addr;
    logic [1:0]  cmd_size;
    logic [31:0] cmd_wdata;
    logic        rsp_valid, rsp_error, rsp_timeout;
    logic [31:0] rsp_rdata;
    logic [6:0]  haddr;
    logic [1:0]  hsize, htrans;
    logic        hwrite, hready, hresp;
    logic [31:0] hwdata, hrdata;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    ahb_lite_master #(.ADDR_W(7), .DATA_W(32), .TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .nRst(nRst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_size(cmd_size), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_error(rsp_error),
        .rsp_timeout(rsp_timeout),
        .haddr(haddr), .hsize(hsize), .hwrite(hwrite), .htrans(htrans),
        .hwdata(hwdata), .hrdata(hrdata), .hready(hready), .hresp(hresp)
    );

    // em: 0 normal, 1 hready-low error then ERR2 (dw extra ERR2 waits), 2 hready-high error
    typedef struct {
        logic        wr;
        logic [6:0]  addr;
        logic [1:0]  sz;
        logic [31:0] wdata;
        logic [31:0] hrd;
        int          aw;
        int          dw;
        int          em;
        logic        ill;
        logic [31:0] exp_hw;
        logic [31:0] exp_rd;
        logic        exp_err;
    } vec_t;

    typedef struct {
        logic [31:0] rd;
        logic        err;
        logic        to;
    } rsp_t;

    rsp_t exp_q[$];
    vec_t vecs[14];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin : mon
        rsp_t r;
        if (nRst && rsp_valid) begin
            if (exp_q.size() == 0) begin
                check("rsp_unexpected", 32'(rsp_valid), 32'd0);
            end else begin
                r = exp_q.pop_front();
                check("rsp_rdata", rsp_rdata, r.rd);
                check("rsp_error", 32'(rsp_error), 32'(r.err));
                check("rsp_timeout", 32'(rsp_timeout), 32'(r.to));
            end
        end
    end

    task automatic run_vec(input vec_t v);
        cmd_valid = 1'b1;
        cmd_write = v.wr;
        cmd_addr  = v.addr;
        cmd_size  = v.sz;
        cmd_wdata = v.wdata;
        check("cmd_ready_idle", 32'(cmd_ready), 32'd1);
        exp_q.push_back('{v.exp_rd, v.exp_err, 1'b0});
        tick();
        cmd_valid = 1'b0;
        if (v.ill) begin
            check("ill_no_nonseq", 32'(htrans), 32'd0);
            check("ill_rsp_valid", 32'(rsp_valid), 32'd1);
            check("ill_cmd_ready", 32'(cmd_ready), 32'd0);
            tick();
            return;
        end
        check("addr_htrans", 32'(htrans), 32'd2);
        check("addr_haddr", 32'(haddr), 32'(v.addr));
        check("addr_hsize", 32'(hsize), 32'(v.sz));
        check("addr_hwrite", 32'(hwrite), 32'(v.wr));
        for (int i = 0; i < v.aw; i++) begin
            hready = 1'b0;
            tick();
            check("addr_hold_htrans", 32'(htrans), 32'd2);
            check("addr_hold_haddr", 32'(haddr), 32'(v.addr));
        end
        hready = 1'b1;
        tick();
        check("data_htrans", 32'(htrans), 32'd0);
        if (v.wr) check("data_hwdata", hwdata, v.exp_hw);
        hrdata = v.hrd;
        case (v.em)
            0: begin
                for (int i = 0; i < v.dw; i++) begin
                    hready = 1'b0;
                    tick();
                    check("wait_htrans", 32'(htrans), 32'd0);
                    check("wait_rsp_valid", 32'(rsp_valid), 32'd0);
                    if (v.wr) check("wait_hwdata", hwdata, v.exp_hw);
                end
                hready = 1'b1;
                tick();
            end
            1: begin
                hready = 1'b0;
                hresp  = 1'b1;
                tick();
                check("err2_htrans", 32'(htrans), 32'd0);
                for (int i = 0; i < v.dw; i++) begin
                    tick();
                    check("err2_wait_htrans", 32'(htrans), 32'd0);
                    check("err2_wait_rsp", 32'(rsp_valid), 32'd0);
                end
                hready = 1'b1;
                tick();
                hresp = 1'b0;
            end
            default: begin
                hready = 1'b1;
                hresp  = 1'b1;
                tick();
                hresp = 1'b0;
            end
        endcase
        check("rsp_valid_cycle", 32'(rsp_valid), 32'd1);
        check("rsp_htrans_idle", 32'(htrans), 32'd0);
        check("rsp_cmd_ready", 32'(cmd_ready), 32'd0);
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = '{1'b0, 7'h48, 2'b00, 32'h0,        32'h123456AB, 0, 0, 0, 1'b0, 32'h0,        32'h000000AB, 1'b0};
        vecs[1]  = '{1'b1, 7'h00, 2'b10, 32'hDEADBEEF, 32'h0,        0, 0, 0, 1'b0, 32'hDEADBEEF, 32'h0,        1'b0};
        vecs[2]  = '{1'b0, 7'h40, 2'b01, 32'h0,        32'hFFFF1234, 0, 0, 0, 1'b0, 32'h0,        32'h00001234, 1'b0};
        vecs[3]  = '{1'b1, 7'h05, 2'b00, 32'h11223344, 32'h0,        0, 0, 0, 1'b0, 32'h00000044, 32'h0,        1'b0};
        vecs[4]  = '{1'b1, 7'h06, 2'b01, 32'hAABBCCDD, 32'h0,        0, 1, 0, 1'b0, 32'h0000CCDD, 32'h0,        1'b0};
        vecs[5]  = '{1'b0, 7'h04, 2'b10, 32'h0,        32'hCAFEF00D, 0, 3, 0, 1'b0, 32'h0,        32'hCAFEF00D, 1'b0};
        vecs[6]  = '{1'b0, 7'h08, 2'b10, 32'h0,        32'h87654321, 2, 0, 0, 1'b0, 32'h0,        32'h87654321, 1'b0};
        vecs[7]  = '{1'b0, 7'h41, 2'b01, 32'h0,        32'h0,        0, 0, 0, 1'b1, 32'h0,        32'h0,        1'b1};
        vecs[8]  = '{1'b0, 7'h10, 2'b11, 32'h0,        32'h0,        0, 0, 0, 1'b1, 32'h0,        32'h0,        1'b1};
        vecs[9]  = '{1'b1, 7'h02, 2'b10, 32'h0,        32'h0,        0, 0, 0, 1'b1, 32'h0,        32'h0,        1'b1};
        vecs[10] = '{1'b0, 7'h0C, 2'b10, 32'h0,        32'h5555AAAA, 0, 0, 1, 1'b0, 32'h0,        32'h0,        1'b1};
        vecs[11] = '{1'b0, 7'h0E, 2'b01, 32'h0,        32'h5555AAAA, 0, 0, 2, 1'b0, 32'h0,        32'h0,        1'b1};
        vecs[12] = '{1'b1, 7'h10, 2'b10, 32'h01020304, 32'h0,        0, 2, 1, 1'b0, 32'h01020304, 32'h0,        1'b1};
        vecs[13] = '{1'b0, 7'h03, 2'b00, 32'h0,        32'hFFFFFF80, 0, 1, 0, 1'b0, 32'h0,        32'h00000080, 1'b0};

        nRst      = 1'b0;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = '0;
        cmd_size  = '0;
        cmd_wdata = '0;
        hready    = 1'b1;
        hresp     = 1'b0;
        hrdata    = '0;
        #12;
        check("rst_htrans", 32'(htrans), 32'd0);
        check("rst_haddr", 32'(haddr), 32'd0);
        check("rst_hwdata", hwdata, 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_error", 32'(rsp_error), 32'd0);
        check("rst_rsp_rdata", rsp_rdata, 32'd0);
        @(negedge clk);
        nRst = 1'b1;
        tick();
        check("post_rst_cmd_ready", 32'(cmd_ready), 32'd1);

        for (int i = 0; i < 14; i++) run_vec(vecs[i]);

        // rsp_rdata holds the last read value while idle
        tick();
        tick();
        check("rdata_hold", rsp_rdata, 32'h00000080);

`ifdef AHBM_TIMEOUT_EN
        cmd_valid = 1'b1;
        cmd_write = 1'b0;
        cmd_addr  = 7'h14;
        cmd_size  = 2'b10;
        exp_q.push_back('{32'h0, 1'b1, 1'b1});
        tick();
        cmd_valid = 1'b0;
        hready    = 1'b0;
        check("to_addr_htrans", 32'(htrans), 32'd2);
        for (int i = 0; i < 15; i++) begin
            tick();
            check("to_wait_htrans", 32'(htrans), 32'd2);
        end
        tick();
        check("to_rsp_valid", 32'(rsp_valid), 32'd1);
        check("to_htrans_idle", 32'(htrans), 32'd0);
        hready = 1'b1;
        tick();
`endif

        // Reset while a command sits in its address phase
        cmd_valid = 1'b1;
        cmd_write = 1'b0;
        cmd_addr  = 7'h20;
        cmd_size  = 2'b10;
        tick();
        cmd_valid = 1'b0;
        hready    = 1'b0;
        check("mid_rst_nonseq", 32'(htrans), 32'd2);
        tick();
        #2;
        nRst = 1'b0;
        #1;
        check("mid_rst_htrans", 32'(htrans), 32'd0);
        check("mid_rst_haddr", 32'(haddr), 32'd0);
        check("mid_rst_rsp", 32'(rsp_valid), 32'd0);
        hready = 1'b1;
        @(negedge clk);
        nRst = 1'b1;
        tick();
        check("mid_rst_ready", 32'(cmd_ready), 32'd1);
        tick();
        check("mid_rst_no_rsp", 32'(rsp_valid), 32'd0);
        run_vec(vecs[0]);

        tick();
        tick();
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
